cpu_axi_bridge: RTL and testbench
=================================

CPU_AXI_BRIDGE -- requirements
Module: cpu_axi_bridge

Interface
REQ-001 SHALL have parameter DATA_RD_FIRST, default 1: data-port read wins AR arbitration over inst-port read.
REQ-002 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports inst_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  CPU fetch request.
REQ-005 SHALL have ports inst_sram_addr_ok/data_ok/rdata  out  1/1/32  fetch handshake and returned instruction.
REQ-006 SHALL have ports data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  CPU load/store request.
REQ-007 SHALL have ports data_sram_addr_ok/data_ok/rdata  out  1/1/32  load/store handshake and load data.
REQ-008 SHALL have ports arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1, and arready  in  1.
REQ-009 SHALL have ports rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1, and rready  out  1.
REQ-010 SHALL have ports awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/8/3/2/2/4/3/1, and awready  in  1.
REQ-011 SHALL have ports wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1, and wready  in  1.
REQ-012 SHALL have ports bid/bresp/bvalid  in  4/2/1, and bready  out  1.

Function
REQ-013 SHALL drive constants arlen=awlen=0, arburst=awburst=2'b01, lock/cache/prot=0, wlast=1, awid=wid=1; arsize/awsize={1'b0,size}.
REQ-014 SHALL use AXI ID 0 for inst reads, ID 1 for data reads; inst_sram_wr=1 ignored (treated as read).
REQ-015 Read FSM states RD_IDLE, RD_AR; RD_IDLE->RD_AR when an eligible read request exists, latching ID/addr/size; RD_AR->RD_IDLE on arvalid&&arready.
REQ-016 arvalid SHALL be 1 exactly in RD_AR; araddr/arsize/arid held stable until handshake.
REQ-017 Per-ID busy flag SHALL be set on AR handshake and cleared on R handshake with matching rid; a port SHALL not be eligible while its flag is set (one outstanding read per ID).
REQ-018 Data read SHALL not be eligible while the write FSM is not WR_IDLE (read-after-write ordering).
REQ-019 Both ports eligible in same cycle: data wins if DATA_RD_FIRST=1, else inst.
REQ-020 inst_sram_addr_ok / data_sram_addr_ok (read) SHALL pulse in the AR handshake cycle of that ID only.
REQ-021 rready SHALL be 1 whenever out of reset; on rvalid, rid=0 -> inst_sram_data_ok=1, inst_sram_rdata=rdata same cycle; rid=1 -> data_sram_data_ok=1, data_sram_rdata=rdata.
REQ-022 Write FSM states WR_IDLE, WR_SEND, WR_RESP; WR_IDLE->WR_SEND on data_sram_req&&wr, latching addr/wdata/wstrb/size, data_sram_addr_ok=1 that cycle.
REQ-023 In WR_SEND awvalid and wvalid SHALL assert together and each drop independently after its own handshake; ->WR_RESP when both done (same or different cycles).
REQ-024 In WR_RESP bready=1 except in cycles with rvalid&&rid==1; B handshake -> data_sram_data_ok=1, ->WR_IDLE.
REQ-025 Data read and write requests same cycle cannot coexist (single data_sram_req); data write acceptance SHALL not be blocked by an outstanding data read.
REQ-026 rresp/bresp SHALL be ignored; no error signalling.

Reset
REQ-027 During/after reset: arvalid=awvalid=wvalid=0, rready=bready=0 while reset high, all addr_ok/data_ok=0, rdata outputs 0, FSMs idle, busy flags 0.
REQ-028 Reset mid-transaction SHALL abandon it; no response delivered afterward for it.

Structure
REQ-029 Package cpu_axi_pkg SHALL hold ID constants (AXI_ID_INST=0, AXI_ID_DATA=1) and RD_*/WR_* state encodings.
REQ-030 Write channel (REQ-022..024) SHALL be sub-module axi_wr_channel; read arbitration stays in top.

Verification
REQ-031 Inst read addr 0x1c000000, arready after 2 cycles, rvalid rid=0 rdata=0x02800c06 -> one inst addr_ok at handshake, inst data_ok with rdata 0x02800c06.
REQ-032 Inst and data reads same cycle -> AR data (arid=1) first, inst second; responses routed by rid even if returned out of order.
REQ-033 Store addr 0x1000 wdata 0xdeadbeef wstrb 0xf, wready 3 cycles before awready -> both handshakes, single B, one data_ok.
REQ-034 Load to 0x1000 right after store -> no AR until bvalid; load then returns 0xdeadbeef.
REQ-035 bvalid and rvalid(rid=1) same cycle -> bready=0 that cycle, load data_ok first, store data_ok next cycle.
REQ-036 Reset asserted while RD_AR holding arvalid -> arvalid=0 immediately, busy flags clear.

Source files
------------

// File: rtl/cpu_axi_pkg.sv
// rtl/cpu_axi_pkg.sv - shared AXI IDs and FSM encodings for the CPU-to-AXI bridge
package cpu_axi_pkg;
  localparam logic [3:0] AXI_ID_INST = 4'd0;
  localparam logic [3:0] AXI_ID_DATA = 4'd1;

  typedef enum logic {RD_IDLE, RD_AR} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_SEND, WR_RESP} wr_state_t;
endpackage

// File: rtl/axi_wr_channel.sv
// rtl/axi_wr_channel.sv - single-beat AW/W/B sequencer for data-port stores
module axi_wr_channel
  import cpu_axi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic        idle,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  input  logic        rvalid,
  input  logic [3:0]  rid
);
  wr_state_t  state;
  logic [1:0] size_q;
  logic       aw_left, w_left;

  assign awsize  = {1'b0, size_q};
  assign idle    = (state == WR_IDLE);
  assign addr_ok = idle && cpu_req && cpu_wr;
  // A data-read response and a store response would both land on data_ok; the read goes first.
  assign bready  = (state == WR_RESP) && !(rvalid && rid == AXI_ID_DATA);
  assign data_ok = bvalid && bready;
  assign aw_left = awvalid && !awready;
  assign w_left  = wvalid && !wready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= WR_IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      awaddr  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
      size_q  <= '0;
    end else begin
      case (state)
        WR_IDLE: if (addr_ok) begin
          awaddr  <= cpu_addr;
          wdata   <= cpu_wdata;
          wstrb   <= cpu_wstrb;
          size_q  <= cpu_size;
          awvalid <= 1'b1;
          wvalid  <= 1'b1;
          state   <= WR_SEND;
        end
        WR_SEND: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (!aw_left && !w_left) state <= WR_RESP;
        end
        WR_RESP: if (data_ok) state <= WR_IDLE;
        default: state <= WR_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/cpu_axi_bridge.sv
// rtl/cpu_axi_bridge.sv - bridges SRAM-like inst/data CPU ports onto one AXI master
module cpu_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter int DATA_RD_FIRST = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  rd_state_t   rd_state;
  logic [1:0]  arsize_q;
  logic        inst_busy, data_busy, wr_idle;
  logic        inst_elig, data_elig, pick_data, ar_hs, r_hs;
  logic        inst_rd_ok, data_rd_ok, wr_addr_ok, wr_data_ok;
  logic        unused;

  assign unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};

  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = AXI_ID_DATA;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = AXI_ID_DATA;
  assign wlast   = 1'b1;

  assign arvalid = (rd_state == RD_AR);
  assign arsize  = {1'b0, arsize_q};
  assign rready  = !reset;
  assign ar_hs   = arvalid && arready;
  assign r_hs    = rvalid && rready;

  // Loads wait for any in-flight store so a load never overtakes a store to the same address.
  assign inst_elig = inst_sram_req && !inst_busy;
  assign data_elig = data_sram_req && !data_sram_wr && !data_busy && wr_idle;
  assign pick_data = data_elig && ((DATA_RD_FIRST != 0) || !inst_elig);

  // Responses are only delivered for reads still tracked, so anything abandoned by reset is dropped.
  assign inst_rd_ok = r_hs && (rid == AXI_ID_INST) && inst_busy;
  assign data_rd_ok = r_hs && (rid == AXI_ID_DATA) && data_busy;

  assign inst_sram_addr_ok = ar_hs && (arid == AXI_ID_INST);
  assign data_sram_addr_ok = (ar_hs && (arid == AXI_ID_DATA)) || wr_addr_ok;
  assign inst_sram_data_ok = inst_rd_ok;
  assign data_sram_data_ok = data_rd_ok || wr_data_ok;
  assign inst_sram_rdata   = inst_rd_ok ? rdata : 32'd0;
  assign data_sram_rdata   = data_rd_ok ? rdata : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state  <= RD_IDLE;
      arid      <= AXI_ID_INST;
      araddr    <= '0;
      arsize_q  <= '0;
      inst_busy <= 1'b0;
      data_busy <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: if (pick_data) begin
          arid     <= AXI_ID_DATA;
          araddr   <= data_sram_addr;
          arsize_q <= data_sram_size;
          rd_state <= RD_AR;
        end else if (inst_elig) begin
          arid     <= AXI_ID_INST;
          araddr   <= inst_sram_addr;
          arsize_q <= inst_sram_size;
          rd_state <= RD_AR;
        end
        RD_AR: if (ar_hs) rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
      if (ar_hs && arid == AXI_ID_INST) inst_busy <= 1'b1;
      else if (r_hs && rid == AXI_ID_INST) inst_busy <= 1'b0;
      if (ar_hs && arid == AXI_ID_DATA) data_busy <= 1'b1;
      else if (r_hs && rid == AXI_ID_DATA) data_busy <= 1'b0;
    end
  end

  axi_wr_channel u_wr (
    .clk(clk), .reset(reset),
    .cpu_req(data_sram_req), .cpu_wr(data_sram_wr), .cpu_size(data_sram_size),
    .cpu_wstrb(data_sram_wstrb), .cpu_addr(data_sram_addr), .cpu_wdata(data_sram_wdata),
    .addr_ok(wr_addr_ok), .data_ok(wr_data_ok), .idle(wr_idle),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .rvalid(rvalid), .rid(rid)
  );
endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb/tb_cpu_axi_bridge.sv - directed self-checking bench for cpu_axi_bridge
module tb_cpu_axi_bridge;
  logic clk, reset;
  logic inst_sram_req, inst_sram_wr; logic [1:0] inst_sram_size; logic [3:0] inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic inst_sram_addr_ok, inst_sram_data_ok; logic [31:0] inst_sram_rdata;
  logic data_sram_req, data_sram_wr; logic [1:0] data_sram_size; logic [3:0] data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic data_sram_addr_ok, data_sram_data_ok; logic [31:0] data_sram_rdata;
  logic [3:0] arid; logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize; logic [1:0] arburst;
  logic [1:0] arlock; logic [3:0] arcache; logic [2:0] arprot; logic arvalid, arready;
  logic [3:0] rid; logic [31:0] rdata; logic [1:0] rresp; logic rlast, rvalid, rready;
  logic [3:0] awid; logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize; logic [1:0] awburst;
  logic [1:0] awlock; logic [3:0] awcache; logic [2:0] awprot; logic awvalid, awready;
  logic [3:0] wid; logic [31:0] wdata; logic [3:0] wstrb; logic wlast, wvalid, wready;
  logic [3:0] bid; logic [1:0] bresp; logic bvalid, bready;

  int vectors = 0;
  int miscompares = 0;

  cpu_axi_bridge #(.DATA_RD_FIRST(1)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk); #1;
    vectors++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin miscompares++;
      $display("FAIL reset_valids got %b want 00000", {arvalid, awvalid, wvalid, rready, bready}); end
    vectors++; if ({inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok} !== 4'b0) begin miscompares++;
      $display("FAIL reset_oks got %b want 0000", {inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok}); end
    vectors++; if ({inst_sram_rdata, data_sram_rdata} !== 64'd0) begin miscompares++;
      $display("FAIL reset_rdata got %h want 0", {inst_sram_rdata, data_sram_rdata}); end
    vectors++; if ({arlen, arburst, awlen, awburst, wlast, awid, wid} !== {8'd0, 2'b01, 8'd0, 2'b01, 1'b1, 4'd1, 4'd1}) begin miscompares++;
      $display("FAIL const_fields got %h", {arlen, arburst, awlen, awburst, wlast, awid, wid}); end
    @(negedge clk); reset = 1'b0; #1;
    vectors++; if (rready !== 1'b1 || arvalid !== 1'b0) begin miscompares++;
      $display("FAIL post_reset rready/arvalid got %b%b want 10", rready, arvalid); end
  endtask

  task automatic test_inst_read();
    int okc = 0;
    @(negedge clk); inst_sram_req = 1; inst_sram_addr = 32'h1c000000; inst_sram_size = 2'd2; #1;
    okc += int'(inst_sram_addr_ok);
    @(negedge clk); #1;
    vectors++; if ({arvalid, arid, araddr, arsize} !== {1'b1, 4'd0, 32'h1c000000, 3'd2}) begin miscompares++;
      $display("FAIL inst_ar got v=%b id=%h a=%h s=%h", arvalid, arid, araddr, arsize); end
    okc += int'(inst_sram_addr_ok);
    @(negedge clk); #1; okc += int'(inst_sram_addr_ok);
    @(negedge clk); arready = 1; #1; okc += int'(inst_sram_addr_ok);
    vectors++; if (inst_sram_addr_ok !== 1'b1) begin miscompares++;
      $display("FAIL inst_addr_ok_at_hs got %b want 1", inst_sram_addr_ok); end
    @(negedge clk); arready = 0; inst_sram_req = 0; #1; okc += int'(inst_sram_addr_ok);
    vectors++; if (okc != 1 || arvalid !== 1'b0) begin miscompares++;
      $display("FAIL inst_addr_ok_count got %0d arvalid=%b want 1/0", okc, arvalid); end
    rvalid = 1; rid = 4'd0; rdata = 32'h02800c06; #1;
    vectors++; if ({inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata} !== {2'b10, 32'h02800c06}) begin miscompares++;
      $display("FAIL inst_resp got ok=%b%b rdata=%h want 10/02800c06", inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata); end
    @(negedge clk); rvalid = 0;
  endtask

  task automatic test_arbitration();
    @(negedge clk); inst_sram_req = 1; inst_sram_addr = 32'h1c000010;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h00000800; data_sram_size = 2'd2;
    @(negedge clk); arready = 1; #1;
    vectors++; if ({arvalid, arid, araddr, data_sram_addr_ok, inst_sram_addr_ok} !== {1'b1, 4'd1, 32'h800, 2'b10}) begin miscompares++;
      $display("FAIL arb_first got id=%h a=%h dok=%b iok=%b want 1/800/1/0", arid, araddr, data_sram_addr_ok, inst_sram_addr_ok); end
    @(negedge clk); arready = 0; data_sram_req = 0;
    @(negedge clk); arready = 1; #1;
    vectors++; if ({arvalid, arid, araddr, inst_sram_addr_ok} !== {1'b1, 4'd0, 32'h1c000010, 1'b1}) begin miscompares++;
      $display("FAIL arb_second got id=%h a=%h iok=%b want 0/1c000010/1", arid, araddr, inst_sram_addr_ok); end
    @(negedge clk); arready = 0; inst_sram_req = 0;
    rvalid = 1; rid = 4'd0; rdata = 32'h11111111; #1;
    vectors++; if ({inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata} !== {2'b10, 32'h11111111}) begin miscompares++;
      $display("FAIL ooo_inst got ok=%b%b rdata=%h", inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata); end
    @(negedge clk); rid = 4'd1; rdata = 32'h22222222; #1;
    vectors++; if ({inst_sram_data_ok, data_sram_data_ok, data_sram_rdata} !== {2'b01, 32'h22222222}) begin miscompares++;
      $display("FAIL ooo_data got ok=%b%b rdata=%h", inst_sram_data_ok, data_sram_data_ok, data_sram_rdata); end
    @(negedge clk); rvalid = 0;
  endtask

  task automatic test_store();
    @(negedge clk); data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1000;
    data_sram_wdata = 32'hdeadbeef; data_sram_wstrb = 4'hf; data_sram_size = 2'd2; #1;
    vectors++; if (data_sram_addr_ok !== 1'b1) begin miscompares++;
      $display("FAIL store_addr_ok got %b want 1", data_sram_addr_ok); end
    @(negedge clk); data_sram_req = 0; wready = 1; #1;
    vectors++; if ({awvalid, wvalid, awaddr, wdata, wstrb, awsize} !== {2'b11, 32'h1000, 32'hdeadbeef, 4'hf, 3'd2}) begin miscompares++;
      $display("FAIL store_aw_w got v=%b%b a=%h d=%h s=%h", awvalid, wvalid, awaddr, wdata, wstrb); end
    @(negedge clk); wready = 0; #1;
    vectors++; if ({awvalid, wvalid} !== 2'b10) begin miscompares++;
      $display("FAIL store_w_drop got %b%b want 10", awvalid, wvalid); end
    @(negedge clk);
    @(negedge clk); awready = 1;
    @(negedge clk); awready = 0; #1;
    vectors++; if ({awvalid, wvalid, bready} !== 3'b001) begin miscompares++;
      $display("FAIL store_resp_wait got %b want 001", {awvalid, wvalid, bready}); end
    bvalid = 1; #1;
    vectors++; if (data_sram_data_ok !== 1'b1) begin miscompares++;
      $display("FAIL store_data_ok got %b want 1", data_sram_data_ok); end
    @(negedge clk); bvalid = 0; #1;
    vectors++; if ({data_sram_data_ok, bready} !== 2'b00) begin miscompares++;
      $display("FAIL store_done got %b want 00", {data_sram_data_ok, bready}); end
  endtask

  task automatic test_load_after_store();
    int early_ar = 0;
    @(negedge clk); data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1000; data_sram_wdata = 32'hdeadbeef;
    @(negedge clk); data_sram_wr = 0; awready = 1; wready = 1; #1;
    early_ar += int'(arvalid) + int'(data_sram_addr_ok);
    @(negedge clk); awready = 0; wready = 0; #1; early_ar += int'(arvalid) + int'(data_sram_addr_ok);
    @(negedge clk); #1; early_ar += int'(arvalid) + int'(data_sram_addr_ok);
    @(negedge clk); bvalid = 1; #1; early_ar += int'(arvalid);
    vectors++; if (early_ar != 0 || data_sram_data_ok !== 1'b1) begin miscompares++;
      $display("FAIL raw_hold got early=%0d ok=%b want 0/1", early_ar, data_sram_data_ok); end
    @(negedge clk); bvalid = 0;
    @(negedge clk); arready = 1; #1;
    vectors++; if ({arvalid, arid, araddr, data_sram_addr_ok} !== {1'b1, 4'd1, 32'h1000, 1'b1}) begin miscompares++;
      $display("FAIL raw_ar got v=%b id=%h a=%h ok=%b", arvalid, arid, araddr, data_sram_addr_ok); end
    @(negedge clk); arready = 0; data_sram_req = 0; rvalid = 1; rid = 4'd1; rdata = 32'hdeadbeef; #1;
    vectors++; if ({data_sram_data_ok, data_sram_rdata} !== {1'b1, 32'hdeadbeef}) begin miscompares++;
      $display("FAIL raw_load got ok=%b rdata=%h", data_sram_data_ok, data_sram_rdata); end
    @(negedge clk); rvalid = 0;
  endtask

  task automatic test_b_r_collision();
    @(negedge clk); data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h2000;
    @(negedge clk); arready = 1;
    @(negedge clk); arready = 0; data_sram_wr = 1; data_sram_addr = 32'h3000; data_sram_wdata = 32'h12345678; #1;
    vectors++; if (data_sram_addr_ok !== 1'b1) begin miscompares++;
      $display("FAIL store_during_load got %b want 1", data_sram_addr_ok); end
    @(negedge clk); data_sram_req = 0; awready = 1; wready = 1;
    @(negedge clk); awready = 0; wready = 0; bvalid = 1; rvalid = 1; rid = 4'd1; rdata = 32'hcafef00d; #1;
    vectors++; if ({bready, data_sram_data_ok, data_sram_rdata} !== {2'b01, 32'hcafef00d}) begin miscompares++;
      $display("FAIL collide_load got bready=%b ok=%b rdata=%h", bready, data_sram_data_ok, data_sram_rdata); end
    @(negedge clk); rvalid = 0; #1;
    vectors++; if ({bready, data_sram_data_ok, data_sram_rdata} !== {2'b11, 32'd0}) begin miscompares++;
      $display("FAIL collide_store got bready=%b ok=%b rdata=%h", bready, data_sram_data_ok, data_sram_rdata); end
    @(negedge clk); bvalid = 0; #1;
    vectors++; if (data_sram_data_ok !== 1'b0) begin miscompares++;
      $display("FAIL collide_done got %b want 0", data_sram_data_ok); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); inst_sram_req = 1; inst_sram_addr = 32'h100;
    @(negedge clk); arready = 1;
    @(negedge clk); arready = 0; inst_sram_req = 0; data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h200;
    @(negedge clk); #1;
    vectors++; if ({arvalid, arid} !== {1'b1, 4'd1}) begin miscompares++;
      $display("FAIL mid_ar_pending got v=%b id=%h", arvalid, arid); end
    #1 reset = 1; #1;
    vectors++; if ({arvalid, awvalid, rready} !== 3'b000) begin miscompares++;
      $display("FAIL mid_reset_async got %b want 000", {arvalid, awvalid, rready}); end
    @(negedge clk); data_sram_req = 0;
    @(negedge clk); reset = 0; rvalid = 1; rid = 4'd0; rdata = 32'h00000bad; #1;
    vectors++; if ({inst_sram_data_ok, rready} !== 2'b01) begin miscompares++;
      $display("FAIL stale_resp got ok=%b rready=%b want 0/1", inst_sram_data_ok, rready); end
    @(negedge clk); rvalid = 0; inst_sram_req = 1; inst_sram_addr = 32'h300;
    @(negedge clk); arready = 1; #1;
    vectors++; if ({arvalid, arid, araddr, inst_sram_addr_ok} !== {1'b1, 4'd0, 32'h300, 1'b1}) begin miscompares++;
      $display("FAIL busy_cleared got v=%b id=%h a=%h ok=%b", arvalid, arid, araddr, inst_sram_addr_ok); end
    @(negedge clk); arready = 0; inst_sram_req = 0; rvalid = 1; rid = 4'd0; rdata = 32'h5a5a5a5a; #1;
    vectors++; if ({inst_sram_data_ok, inst_sram_rdata} !== {1'b1, 32'h5a5a5a5a}) begin miscompares++;
      $display("FAIL post_reset_read got ok=%b rdata=%h", inst_sram_data_ok, inst_sram_rdata); end
    @(negedge clk); rvalid = 0;
  endtask

  initial begin
    reset = 1;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_wstrb = 0; inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 0; data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;
    test_reset();
    test_inst_read();
    test_arbitration();
    test_store();
    test_load_after_store();
    test_b_r_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
